hazard_sched_ctrl: RTL
======================

// Module: hazard_sched_ctrl
// PURPOSE
//   Central pipeline sequencer for the 5-stage F/D/E/M/W core. Each cycle it decides stage enables,
//   bubble/flush injection and PC-source selection from decode, execute and memory stage status.
//   It handles load-use stalls, BCOND/JAL redirects and multi-cycle data-memory waits with a timeout.
//   It drives the PC register enable, the F/D, D/E, E/M and M/W buffer enables/flushes, and the PC select mux.
// PARAMETERS
//   OPBITS      4        opcode field width
//   REGBITS     4        register index width
//   LW_OP       4'b0111  load opcode
//   SW_OP       4'b0011  store opcode
//   BCOND_OP    4'b0010  conditional-branch opcode
//   JAL_OP      4'b0110  jump-and-link opcode
//   MEM_TIMEOUT 16       max MEM_WAIT cycles before forced release (>=2)
//   CNT_BITS    16       width of performance counters
// PORTS
//   clk           in   1        pipeline clock
//   rst_n         in   1        asynchronous active-low reset
//   op_D          in   OPBITS   decode-stage opcode
//   rs1_D, rs2_D  in   REGBITS  decode-stage source indices
//   use_rs1_D     in   1        decode instruction reads rs1
//   use_rs2_D     in   1        decode instruction reads rs2
//   op_E, rd_E    in   OPBITS/REGBITS  execute-stage opcode, destination
//   wen_E, noop_E in   1        execute regfile write enable, bubble flag
//   op_M          in   OPBITS   memory-stage opcode
//   cond_M        in   1        branch condition result latched for the M stage
//   noop_M        in   1        memory-stage bubble flag
//   mem_ready     in   1        data memory completes the access this cycle
//   pc_en         out  1        PC register write enable
//   fd_en, de_en, em_en  out 1  F/D, D/E, E/M buffer enables
//   fd_flush      out  1        load NOP into F/D
//   de_bubble     out  1        load bubble into D/E
//   em_bubble     out  1        load bubble into E/M
//   mw_bubble     out  1        load bubble into M/W
//   pc_sel        out  2        00 PC+4, 01 branch target, 10 JAL target
//   mem_err       out  1        sticky: memory timeout occurred
//   stall_cnt     out  CNT_BITS saturating count of load-use plus mem-wait stall cycles
//   flush_cnt     out  CNT_BITS saturating count of redirects taken
// BEHAVIOUR
//   Reset (async, rst_n=0): state=RUN, wait counter=0, mem_err=0, stall_cnt=flush_cnt=0.
//     During reset all enables are 1, all bubbles and flushes are 0, and pc_sel=00.
//   Defaults in RUN with no event: all enables=1, all bubbles/flush=0, pc_sel=00.
//   Events, all decoded combinationally in the same cycle:
//     memreq = !noop_M && (op_M==LW_OP || op_M==SW_OP)
//     redir  = !noop_M && ((op_M==BCOND_OP && cond_M) || op_M==JAL_OP)
//     luse   = !noop_E && wen_E && op_E==LW_OP &&
//              ((use_rs1_D && rs1_D==rd_E) || (use_rs2_D && rs2_D==rd_E))
//     Register 0 is compared like any other index.
//   Priority: memory wait > redirect > load-use.
//   FSM RUN:
//     memreq && !mem_ready:
//       pc_en=fd_en=de_en=em_en=0, mw_bubble=1.
//       Next state MEM_WAIT; wait counter loads 1; stall_cnt+1.
//     else if redir:
//       pc_sel=01 (BCOND) or 10 (JAL); fd_flush=de_bubble=em_bubble=1; flush_cnt+1.
//       Enables stay 1. A simultaneous luse is discarded because the younger instructions are killed.
//     else if luse:
//       pc_en=fd_en=0, de_bubble=1; stall_cnt+1. Lasts exactly 1 cycle; the load has then moved to M.
//   FSM MEM_WAIT:
//     Outputs are as in the RUN memory-wait case. The M stage is frozen, so op_M is held stable.
//     mem_ready=1: in this same cycle, all enables=1 and mw_bubble=0. Next state RUN.
//       A redirect cannot coexist with memreq, because the M stage holds only one instruction.
//     Else, wait counter == MEM_TIMEOUT-1:
//       Set mem_err=1 and treat the access as complete, with the same outputs as mem_ready=1.
//       Next state RUN.
//     Else the wait counter increments and stall_cnt increments.
//   Counters saturate at all-ones and never wrap.
//   Asserting rst_n low mid-wait aborts immediately to RUN and clears all state.
//   Only the FSM state, wait counter, mem_err and perf counters are registered.
//   Every control output is a function of current inputs and state, with zero-cycle latency.
// TESTING
//   1 Reset: rst_n=0 mid-MEM_WAIT -> pc_en=1, mw_bubble=0, stall_cnt=0, mem_err=0 with no clock edge.
//   2 Load-use: op_E=LW,rd_E=3,wen_E=1; D reads rs2=3 -> one cycle with pc_en=0,fd_en=0,de_bubble=1.
//     Next cycle (op_E=bubble): all enables=1; stall_cnt=1.
//   3 Redirects: op_M=BCOND,cond_M=1 -> pc_sel=01, fd_flush=de_bubble=em_bubble=1, flush_cnt=1.
//     op_M=JAL -> pc_sel=10.
//     op_M=BCOND,cond_M=0 -> pc_sel=00, no flush.
//     Redirect together with luse -> no pc_en drop.
//   4 Memory wait: op_M=LW, mem_ready low for 3 cycles then high.
//     -> pc_en=0 and mw_bubble=1 for 3 cycles; release in the 4th cycle; stall_cnt=3.
//   5 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> release in cycle 4 and mem_err=1.
//     mem_err stays 1 after later normal accesses until reset.
//   6 Saturation: CNT_BITS=4, 20 load-use events -> stall_cnt=4'hF, holds.
//     noop_E=1 with a matching load -> no stall.

Source files
------------

// File: rtl/hazard_sched_ctrl_if.sv
// Pipeline status inputs and sequencer control outputs for the 5-stage core.
// The master side is the sequencer. The slave side is the pipeline datapath.
interface hazard_sched_ctrl_if #(
    parameter int OPBITS   = 4,
    parameter int REGBITS  = 4,
    parameter int CNT_BITS = 16
);
    // Decode / execute / memory stage status
    logic [OPBITS-1:0]   op_D;
    logic [REGBITS-1:0]  rs1_D;
    logic [REGBITS-1:0]  rs2_D;
    logic                use_rs1_D;
    logic                use_rs2_D;
    logic [OPBITS-1:0]   op_E;
    logic [REGBITS-1:0]  rd_E;
    logic                wen_E;
    logic                noop_E;
    logic [OPBITS-1:0]   op_M;
    logic                cond_M;
    logic                noop_M;
    logic                mem_ready;

    // Stage control
    logic                pc_en;
    logic                fd_en;
    logic                de_en;
    logic                em_en;
    logic                fd_flush;
    logic                de_bubble;
    logic                em_bubble;
    logic                mw_bubble;
    logic [1:0]          pc_sel;
    logic                mem_err;
    logic [CNT_BITS-1:0] stall_cnt;
    logic [CNT_BITS-1:0] flush_cnt;

    modport master (
        input  op_D, rs1_D, rs2_D, use_rs1_D, use_rs2_D,
        input  op_E, rd_E, wen_E, noop_E,
        input  op_M, cond_M, noop_M, mem_ready,
        output pc_en, fd_en, de_en, em_en,
        output fd_flush, de_bubble, em_bubble, mw_bubble,
        output pc_sel, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        output op_D, rs1_D, rs2_D, use_rs1_D, use_rs2_D,
        output op_E, rd_E, wen_E, noop_E,
        output op_M, cond_M, noop_M, mem_ready,
        input  pc_en, fd_en, de_en, em_en,
        input  fd_flush, de_bubble, em_bubble, mw_bubble,
        input  pc_sel, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sched_ctrl.sv
// Central pipeline sequencer: stage enables, bubbles/flushes and PC select
// from load-use hazards, M-stage redirects and multi-cycle memory waits.
module hazard_sched_ctrl #(
    parameter int                OPBITS      = 4,
    parameter int                REGBITS     = 4,
    parameter logic [OPBITS-1:0] LW_OP       = 4'b0111,
    parameter logic [OPBITS-1:0] SW_OP       = 4'b0011,
    parameter logic [OPBITS-1:0] BCOND_OP    = 4'b0010,
    parameter logic [OPBITS-1:0] JAL_OP      = 4'b0110,
    parameter int                MEM_TIMEOUT = 16,
    parameter int                CNT_BITS    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_sched_ctrl_if.master  bus
);
    localparam int                WBITS     = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WBITS-1:0]  W_ONE     = WBITS'(1);
    localparam logic [WBITS-1:0]  W_LAST    = WBITS'(MEM_TIMEOUT - 1);
    localparam logic [CNT_BITS-1:0] C_ONE   = CNT_BITS'(1);

    typedef enum logic {
        S_RUN,
        S_MEM_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WBITS-1:0]    r_wait_cnt;
    logic [WBITS-1:0]    w_wait_cnt_nxt;
    logic                r_mem_err;
    logic [CNT_BITS-1:0] r_stall_cnt;
    logic [CNT_BITS-1:0] r_flush_cnt;

    logic       w_memreq;
    logic       w_redir;
    logic       w_luse;
    logic       w_err_set;
    logic       w_stall_inc;
    logic       w_flush_inc;
    logic       w_pc_en, w_fd_en, w_de_en, w_em_en;
    logic       w_fd_flush, w_de_bubble, w_em_bubble, w_mw_bubble;
    logic [1:0] w_pc_sel;

    // Hazard event decode from the current stage status
    always_comb begin
        w_memreq = !bus.noop_M && (bus.op_M == LW_OP || bus.op_M == SW_OP);
        w_redir  = !bus.noop_M && ((bus.op_M == BCOND_OP && bus.cond_M) || bus.op_M == JAL_OP);
        w_luse   = !bus.noop_E && bus.wen_E && bus.op_E == LW_OP &&
                   ((bus.use_rs1_D && bus.rs1_D == bus.rd_E) ||
                    (bus.use_rs2_D && bus.rs2_D == bus.rd_E));
    end

    // Next state and zero-latency control outputs; held at defaults while in reset
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves a latch.
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_err_set      = 1'b0;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;
        w_pc_en        = 1'b1;
        w_fd_en        = 1'b1;
        w_de_en        = 1'b1;
        w_em_en        = 1'b1;
        w_fd_flush     = 1'b0;
        w_de_bubble    = 1'b0;
        w_em_bubble    = 1'b0;
        w_mw_bubble    = 1'b0;
        w_pc_sel       = 2'b00;

        if (rst_n) begin
            unique case (r_state)
                S_RUN: begin
                    if (w_memreq && !bus.mem_ready) begin
                        {w_pc_en, w_fd_en, w_de_en, w_em_en} = 4'b0000;
                        w_mw_bubble    = 1'b1;
                        w_state_nxt    = S_MEM_WAIT;
                        w_wait_cnt_nxt = W_ONE;
                        w_stall_inc    = 1'b1;
                    end else if (w_redir) begin
                        w_pc_sel    = (bus.op_M == JAL_OP) ? 2'b10 : 2'b01;
                        w_fd_flush  = 1'b1;
                        w_de_bubble = 1'b1;
                        w_em_bubble = 1'b1;
                        w_flush_inc = 1'b1;
                    end else if (w_luse) begin
                        w_pc_en     = 1'b0;
                        w_fd_en     = 1'b0;
                        w_de_bubble = 1'b1;
                        w_stall_inc = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.mem_ready || r_wait_cnt == W_LAST) begin
                        // Release: the timeout path completes the access but flags it
                        w_state_nxt    = S_RUN;
                        w_wait_cnt_nxt = '0;
                        w_err_set      = !bus.mem_ready;
                    end else begin
                        {w_pc_en, w_fd_en, w_de_en, w_em_en} = 4'b0000;
                        w_mw_bubble    = 1'b1;
                        w_wait_cnt_nxt = r_wait_cnt + W_ONE;
                        w_stall_inc    = 1'b1;
                    end
                end
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    // State, wait counter, sticky error and saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of order.
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_err_set)
                r_mem_err <= 1'b1;
            if (w_stall_inc && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + C_ONE;
            if (w_flush_inc && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + C_ONE;
        end
    end

    assign bus.pc_en     = w_pc_en;
    assign bus.fd_en     = w_fd_en;
    assign bus.de_en     = w_de_en;
    assign bus.em_en     = w_em_en;
    assign bus.fd_flush  = w_fd_flush;
    assign bus.de_bubble = w_de_bubble;
    assign bus.em_bubble = w_em_bubble;
    assign bus.mw_bubble = w_mw_bubble;
    assign bus.pc_sel    = w_pc_sel;
    assign bus.mem_err   = r_mem_err;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
endmodule
